debounce_multi: RTL and testbench
=================================

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 The block SHALL have parameter N, default 4: number of independent input channels, N >= 1.
REQ-002 The block SHALL have parameter STABLE, default 16: consecutive cycles a changed level must persist before it is accepted, STABLE >= 1.
REQ-003 The block SHALL have parameter PULSE, default 2: length in cycles of the release pulse, PULSE >= 1.
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous and active-low.
REQ-006 Port: din  input  N  raw, asynchronous, bouncing inputs (buttons).
REQ-007 Port: dout  output  N  debounced level per channel.
REQ-008 Port: rise  output  N  one-cycle strobe when dout goes 0->1.
REQ-009 Port: fall  output  N  one-cycle strobe when dout goes 1->0.
REQ-010 Port: pulse  output  N  PULSE-cycle strobe issued on each press-then-release.

Function
REQ-011 Each channel SHALL be fully independent; no shared counters or state.
REQ-012 Each din bit SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-013 Each channel SHALL hold a stability counter of width clog2(STABLE+1); it SHALL clear to 0 on any edge where s2 == dout.
REQ-014 On an edge where s2 != dout and counter < STABLE-1, the counter SHALL increment by 1.
REQ-015 On an edge where s2 != dout and counter == STABLE-1, dout SHALL take s2 and the counter SHALL clear; the counter never wraps.
REQ-016 Latency: din changed before sampling edge 1 and held SHALL appear on dout after edge STABLE+2; a change lasting fewer than STABLE cycles at s2 SHALL never reach dout.
REQ-017 rise/fall SHALL be registered and high exactly in the cycle dout first shows its new value, low otherwise; never both high in one channel.
REQ-018 The pulse FSM per channel SHALL have states IDLE, ARMED, PULSE, plus a pulse counter of width clog2(PULSE+1).
REQ-019 IDLE -> ARMED on the edge dout goes 1; ARMED -> PULSE (counter 0) on the edge dout goes 0; otherwise hold.
REQ-020 In PULSE the counter SHALL increment each edge; on counter == PULSE-1 the FSM SHALL go to ARMED if dout == 1 at that edge, else IDLE.
REQ-021 pulse SHALL equal (state == PULSE): rises with fall, high exactly PULSE cycles.
REQ-022 A rise occurring during PULSE SHALL NOT shorten or restart the pulse; a fall during PULSE SHALL NOT start a second pulse.
REQ-023 STABLE = 1 SHALL give dout = s2 delayed one edge; PULSE = 1 SHALL give a single-cycle pulse.

Reset
REQ-024 While rst is low, s1, s2, dout, rise, fall, pulse, all counters SHALL be 0 and every FSM IDLE, asserting immediately without a clock edge.
REQ-025 Reset asserted mid-count or mid-pulse SHALL abort it; no partial strobe may appear after release.
REQ-026 A din held 1 through reset release SHALL be treated as a new press: rise after edge STABLE+2 following release.

Verification (N=4, STABLE=4, PULSE=2)
REQ-027 Clean press: din[0] 0->1 held -> dout[0]=1 and rise[0]=1 after edge 6, rise[0] low after edge 7; channels 1-3 stay 0.
REQ-028 Bounce: din[1] toggles 1,0,1,0 on successive cycles then holds 1 -> exactly one rise[1], after edge 6 counted from the final 0->1.
REQ-029 Glitch: din[2] high for 3 cycles then 0 -> dout[2], rise[2], fall[2], pulse[2] remain 0 throughout.
REQ-030 Release: after press on ch0, din[0] 1->0 held -> fall[0] and pulse[0] high after edge 6; pulse[0] high 2 cycles, FSM back to IDLE.
REQ-031 Simultaneous: ch2 press and ch3 release complete on same edge -> rise[2], fall[3], pulse[3] together; no cross-channel effect.
REQ-032 Reset mid-count: din[0]=1, rst low after edge 3 -> all outputs 0 at once; rst high with din[0]=1 -> rise[0] after edge 6 post-release.

Source files
------------

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_multi
//  Purpose  : N independent button debouncers. Each channel synchronises its
//             raw input, accepts a new level only after it has persisted for
//             STABLE consecutive cycles, reports accepted edges as one-cycle
//             strobes and issues a PULSE-cycle strobe on every
//             press-then-release.
//  Ports    : clk   - sole clock, rising edge
//             rst   - asynchronous, active-low reset
//             din   - [N-1:0] raw bouncing inputs
//             dout  - [N-1:0] debounced level
//             rise  - [N-1:0] one-cycle strobe, dout 0->1
//             fall  - [N-1:0] one-cycle strobe, dout 1->0
//             pulse - [N-1:0] PULSE-cycle strobe, starts with fall after a press
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_multi #(
    parameter int N      = 4,
    parameter int STABLE = 16,
    parameter int PULSE  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] pulse
);

    localparam int c_SW = $clog2(STABLE + 1);
    localparam int c_PW = $clog2(PULSE + 1);

    localparam logic [c_SW-1:0] c_SMAX = c_SW'(STABLE - 1);
    localparam logic [c_SW-1:0] c_SONE = c_SW'(1);
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(PULSE - 1);
    localparam logic [c_PW-1:0] c_PONE = c_PW'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ARMED = 2'd1;
    localparam logic [1:0] c_PULSE = 2'd2;

    // Two-flop synchroniser for every raw input.
    logic [N-1:0] r_s1;
    logic [N-1:0] r_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [c_SW-1:0] r_cnt;
        logic            r_dout;
        logic            r_rise;
        logic            r_fall;
        logic            w_accept;
        logic            w_dout_nxt;
        logic            w_rise_evt;
        logic            w_fall_evt;

        logic [1:0]      r_state;
        logic [1:0]      w_state_nxt;
        logic [c_PW-1:0] r_pcnt;
        logic [c_PW-1:0] w_pcnt_nxt;
        logic            w_pulse;

        // The new level is taken on the STABLE-th consecutive mismatching edge.
        assign w_accept   = (r_s2[i] != r_dout) && (r_cnt == c_SMAX);
        assign w_dout_nxt = w_accept ? r_s2[i] : r_dout;
        assign w_rise_evt = w_accept &&  r_s2[i];
        assign w_fall_evt = w_accept && !r_s2[i];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt  <= '0;
                r_dout <= 1'b0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                if (r_s2[i] == r_dout) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_cnt  <= '0;
                    r_dout <= r_s2[i];
                end else begin
                    r_cnt <= r_cnt + c_SONE;
                end
                r_rise <= w_rise_evt;
                r_fall <= w_fall_evt;
            end
        end

        // Pulse FSM: state register.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= c_IDLE;
                r_pcnt  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_pcnt  <= w_pcnt_nxt;
            end
        end

        // Pulse FSM: next state. Transitions follow the level dout takes on
        // this edge, so the pulse starts together with the fall strobe and a
        // press landing on the last pulse edge is not lost.
        always_comb begin
            w_state_nxt = r_state;
            w_pcnt_nxt  = '0;
            case (r_state)
                c_IDLE: begin
                    if (w_rise_evt) begin
                        w_state_nxt = c_ARMED;
                    end
                end
                c_ARMED: begin
                    if (w_fall_evt) begin
                        w_state_nxt = c_PULSE;
                    end
                end
                c_PULSE: begin
                    if (r_pcnt == c_PMAX) begin
                        w_state_nxt = w_dout_nxt ? c_ARMED : c_IDLE;
                    end else begin
                        w_pcnt_nxt = r_pcnt + c_PONE;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end

        // Pulse FSM: outputs.
        always_comb begin
            w_pulse = (r_state == c_PULSE);
        end

        assign dout[i]  = r_dout;
        assign rise[i]  = r_rise;
        assign fall[i]  = r_fall;
        assign pulse[i] = w_pulse;
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debounce_multi
//  Purpose  : Self-checking bench for debounce_multi (N=4, STABLE=4, PULSE=2).
//             Directed press/release/reset scenarios with fixed expectations,
//             then randomised bouncing inputs compared every cycle against a
//             window-based behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_multi;

    localparam int N      = 4;
    localparam int STABLE = 4;
    localparam int PULSE  = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] din;
    logic [N-1:0] dout;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] pulse;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    debounce_multi #(
        .N      (N),
        .STABLE (STABLE),
        .PULSE  (PULSE)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .dout  (dout),
        .rise  (rise),
        .fall  (fall),
        .pulse (pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the synchroniser is a two-sample delay line; a new
    // level is accepted once the last STABLE synchronised samples all
    // disagree with the current debounced level. A pulse runs PULSE cycles
    // from a fall that follows a press; when it ends, a level of 1 counts
    // as a pending press.
    // ------------------------------------------------------------------
    bit [N-1:0]      m_q1, m_q2;
    bit [STABLE-1:0] m_win [N];
    bit [N-1:0]      m_dout, m_rise, m_fall, m_armed;
    int              m_left [N];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q1 = '0; m_q2 = '0;
            m_dout = '0; m_rise = '0; m_fall = '0; m_armed = '0;
            for (int c = 0; c < N; c++) begin
                m_win[c]  = '0;
                m_left[c] = 0;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                bit samp, acc;
                samp     = m_q2[c];
                m_win[c] = {m_win[c][STABLE-2:0], samp};
                acc      = m_dout[c] ? (m_win[c] == '0) : (m_win[c] == '1);
                if (acc) m_dout[c] = samp;
                m_rise[c] = acc &&  samp;
                m_fall[c] = acc && !samp;
                if (m_left[c] > 0) begin
                    m_left[c]--;
                    if (m_left[c] == 0) m_armed[c] = m_dout[c];
                end else if (m_fall[c] && m_armed[c]) begin
                    m_left[c]  = PULSE;
                    m_armed[c] = 1'b0;
                end else if (m_rise[c]) begin
                    m_armed[c] = 1'b1;
                end
            end
            m_q2 = m_q1;
            m_q1 = din;
        end
    end

    always @(negedge clk) begin
        if (rst && chk_en) begin
            bit [N-1:0] exp_p;
            for (int c = 0; c < N; c++) exp_p[c] = (m_left[c] > 0);
            chk("dout",  32'(dout),  32'(m_dout));
            chk("rise",  32'(rise),  32'(m_rise));
            chk("fall",  32'(fall),  32'(m_fall));
            chk("pulse", 32'(pulse), 32'(exp_p));
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"},  32'(dout),  32'd0);
        chk({tag, "_rise"},  32'(rise),  32'd0);
        chk({tag, "_fall"},  32'(fall),  32'd0);
        chk({tag, "_pulse"}, 32'(pulse), 32'd0);
    endtask

    int hold [N];

    initial begin
        rst = 1'b0;
        din = '0;
        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b1;

        // Clean press on channel 0: visible after edge STABLE+2 = 6.
        @(negedge clk);
        din = 4'b0001;
        repeat (5) @(posedge clk);
        #1 chk("press_e5_dout", 32'(dout), 32'h0);
        @(posedge clk);
        #1 chk("press_e6_dout", 32'(dout), 32'h1);
        chk("press_e6_rise", 32'(rise), 32'h1);
        @(posedge clk);
        #1 chk("press_e7_rise", 32'(rise), 32'h0);

        // Release on channel 0: fall and a two-cycle pulse from edge 6.
        repeat (3) @(negedge clk);
        din = 4'b0000;
        repeat (5) @(posedge clk);
        #1 chk("rel_e5_pulse", 32'(pulse), 32'h0);
        @(posedge clk);
        #1 chk("rel_e6_fall", 32'(fall), 32'h1);
        chk("rel_e6_pulse", 32'(pulse), 32'h1);
        @(posedge clk);
        #1 chk("rel_e7_fall", 32'(fall), 32'h0);
        chk("rel_e7_pulse", 32'(pulse), 32'h1);
        @(posedge clk);
        #1 chk("rel_e8_pulse", 32'(pulse), 32'h0);

        // Reset in the middle of a count, input held through release.
        repeat (3) @(negedge clk);
        din = 4'b0001;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("rstrel_e5_dout", 32'(dout), 32'h0);
        @(posedge clk);
        #1 chk("rstrel_e6_rise", 32'(rise), 32'h1);

        // Randomised bouncing: a mix of short glitches and long holds.
        for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 10);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc % 700 == 350) begin
                #3 rst = 1'b0;
                #1 chk_all_zero("rnd_rst");
                @(negedge clk);
                rst = 1'b1;
            end
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    din[c]  = ~din[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                           : $urandom_range(4, 12);
                end else begin
                    hold[c]--;
                end
            end
        end

        repeat (20) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
